id_stage: RTL and testbench
===========================

# id_stage

Parametrised MIPS decode stage with an integrated ID/EX pipeline register. It decodes the R-type logic, shift, compare and add/sub instructions and the I-type logic and arithmetic immediates, and resolves operands through EX/MEM forwarding. It detects load-use hazards and presents a registered, handshaked bundle to the execute stage. It sits between the IF/ID register and `ex`, and reads the regfile combinationally through two read ports.

## Interface
- `DATA_W`, default 32: operand and immediate width (≥32; immediates extend to `DATA_W`).
- `REG_AW`, default 5: register address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `inst_i`/`pc_i` valid.
- `in_ready` out 1: stage accepts instruction this cycle.
- `pc_i` in 32: instruction address.
- `inst_i` in 32: instruction word.
- `reg1_read_o`, `reg2_read_o` out 1: port read enables (combinational).
- `reg1_addr_o`, `reg2_addr_o` out `REG_AW`: rs / rt (combinational).
- `reg1_data_i`, `reg2_data_i` in `DATA_W`: regfile read data.
- `ex_wreg_i`, `ex_is_load_i` in 1: EX-stage write enable; EX instruction is a load.
- `ex_wd_i` in `REG_AW`, `ex_wdata_i` in `DATA_W`: EX destination and result.
- `mem_wreg_i` in 1, `mem_wd_i` in `REG_AW`, `mem_wdata_i` in `DATA_W`: MEM destination and result.
- `flush_i` in 1: discard the held bundle and the current input.
- `out_valid` out 1: bundle valid.
- `out_ready` in 1: EX accepts the bundle.
- `aluop_o` out 8, `alusel_o` out 3, `reg1_o`/`reg2_o` out `DATA_W`, `wd_o` out `REG_AW`, `wreg_o` out 1, `pc_o` out 32: registered bundle.
- `inst_invalid_o` out 1: registered; bundle came from an unrecognised opcode.

## Operation
- Decode is combinational from `inst_i`.
- R-type: `wd` = inst[15:11]. I-type: `wd` = inst[20:16].
- ANDI/ORI/XORI: zero-extended imm. SLTI/SLTIU/ADDI/ADDIU: sign-extended imm.
- LUI: `OR_OP`, reg1 = 0 (forced, not read), reg2 = {inst[15:0], 16'h0}.
- SLL/SRL/SRA: reg1 = zero-extended shamt (inst[10:6]), reg2 = rt.
- SLLV/SRLV/SRAV: reg1 = rs, reg2 = rt.
- Immediate forms: reg2 = imm, reg1 = rs.
- Unrecognised opcode/funct: `NOP_OP`/`RES_NOP`, `wreg`=0, both reads 0, `inst_invalid_o`=1 when captured; still flows as a bubble-like bundle.
- Operand source priority: `$0` → 0 always. Then EX match (`ex_wreg_i` && `ex_wd_i`==addr). Then MEM match. Then regfile.
- Load-use stall (`stall`): `ex_is_load_i` && `ex_wreg_i` && `ex_wd_i`≠0 && `ex_wd_i` equals an enabled read address.
- `in_ready` = !stall && (!out_valid || out_ready) && !flush_i.
- Capture (`in_valid` && `in_ready`): register the bundle; `out_valid`←1.
- Else if `out_ready`: `out_valid`←0.
- Stall with a free output slot: `out_valid`←0 (bubble inserted); EX sees NOP.
- Priority: `flush_i` over capture over drain. A flush sets `out_valid`←0, clears `wreg_o`, and sets `aluop_o`←NOP.

## Timing
- Decode to bundle: 1 cycle. A bundle captured at edge N is visible after N.
- Back-to-back throughput is 1/cycle while `out_ready`=1.
- Load-use costs exactly 1 bubble. The load advances to MEM and the MEM path then forwards.
- Reset values: `out_valid`=0, `aluop_o`=NOP_OP, `alusel_o`=RES_NOP, `reg1_o`=`reg2_o`=0, `wd_o`=0, `wreg_o`=0, `pc_o`=0, `inst_invalid_o`=0.
- Reset mid-operation drops the held bundle immediately (asynchronous).
- While `out_valid`=1 and `out_ready`=0, all bundle outputs hold stable.
- Simultaneous EX and MEM matches on the same register: EX wins.

## Configuration
- `ID_FORWARD_EN` defined: EX/MEM forwarding as above; only load-use stalls.
- `ID_FORWARD_EN` undefined: no forwarding; operands come from the regfile only.
  - `stall` asserts on any enabled read that matches an in-flight EX or MEM write to a nonzero register.
  - Stalls last until the writer retires (up to 2 cycles).

## Structure
- Shared package (`defines.v`): opcode/funct codes, `EXE_*_OP` aluop codes, `EXE_RES_*` alusel codes, `NOPRegAddr`, `ZeroWord`, `RstEnable`.
- Sub-module `id_decode`: a purely combinational opcode decoder that outputs aluop, alusel, read enables, `wd`, `wreg`, imm and invalid.
- `id_stage` holds operand muxing, the hazard logic and the pipeline register.

## Test plan
- ORI $1,$0,0x8001 → `reg1_o`=0, `reg2_o`=0x00008001, `wd_o`=1, `wreg_o`=1, one cycle later.
- ADDI with inst[15:0]=0xFFFF → `reg2_o`=0xFFFFFFFF. LUI 0x1234 → `aluop_o`=OR_OP, `reg1_o`=0, `reg2_o`=0x12340000.
- ADD $3,$1,$2 with EX writing $1=5 and MEM writing $1=7 and $2=9 → `reg1_o`=5, `reg2_o`=9. A write to $0 is never forwarded.
- EX is a load to $4, then AND $5,$4,$6 → `in_ready`=0 for 1 cycle, bubble (`out_valid`=0), then a valid bundle using the MEM-forwarded value.
- Hold `out_ready`=0 for 3 cycles with a bundle held → bundle stable, `in_ready`=0. Assert `flush_i` → `out_valid`=0 next cycle.
- funct 0x3F → `inst_invalid_o`=1, `wreg_o`=0. Assert `rst` low mid-stream → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pkg
// Brief    : Shared MIPS decode constants: opcode/funct codes, aluop and
//            alusel encodings, reset/zero helpers.
// Revision : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU operation codes seen by EX; immediate forms reuse the R-type codes
  localparam logic [7:0] EXE_NOP_OP  = 8'h00;
  localparam logic [7:0] EXE_SRL_OP  = 8'h02;
  localparam logic [7:0] EXE_SRA_OP  = 8'h03;
  localparam logic [7:0] EXE_SLLV_OP = 8'h04;
  localparam logic [7:0] EXE_SRLV_OP = 8'h06;
  localparam logic [7:0] EXE_SRAV_OP = 8'h07;
  localparam logic [7:0] EXE_ADD_OP  = 8'h20;
  localparam logic [7:0] EXE_ADDU_OP = 8'h21;
  localparam logic [7:0] EXE_SUB_OP  = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP = 8'h23;
  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27;
  localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_SLL_OP  = 8'h7C;

  // Result-class selectors
  localparam logic [2:0] EXE_RES_NOP        = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [4:0]  NOPRegAddr = 5'd0;
  localparam logic [31:0] ZeroWord   = 32'h0;
  localparam logic        RstEnable  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/id_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_decode
// Brief    : Purely combinational MIPS opcode/funct decoder. Produces aluop,
//            alusel, read enables, destination, write enable, the operand
//            values used in place of register reads, and an invalid flag.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       i_inst,
  output logic [7:0]        o_aluop,
  output logic [2:0]        o_alusel,
  output logic              o_re1,
  output logic              o_re2,
  output logic [REG_AW-1:0] o_wd,
  output logic              o_wreg,
  output logic [DATA_W-1:0] o_imm1,
  output logic [DATA_W-1:0] o_imm2,
  output logic              o_invalid
);

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [DATA_W-1:0] w_zimm;
  logic [DATA_W-1:0] w_simm;
  logic [DATA_W-1:0] w_shamt;
  logic              w_shift_imm;
  logic              w_itype;
  logic              w_unused_rs;

  assign w_op        = i_inst[31:26];
  assign w_funct     = i_inst[5:0];
  assign w_zimm      = DATA_W'(i_inst[15:0]);
  assign w_simm      = {{(DATA_W-16){i_inst[15]}}, i_inst[15:0]};
  assign w_shamt     = DATA_W'(i_inst[10:6]);
  // rs is only consumed by the operand path in the parent
  assign w_unused_rs = ^i_inst[25:21];

  // Decode opcode/funct into control fields; unknown encodings become a NOP bundle
  always_comb begin
    o_aluop     = EXE_NOP_OP;
    o_alusel    = EXE_RES_NOP;
    o_re1       = 1'b0;
    o_re2       = 1'b0;
    o_wd        = '0;
    o_wreg      = 1'b0;
    o_imm1      = '0;
    o_imm2      = '0;
    o_invalid   = 1'b0;
    w_shift_imm = 1'b0;
    w_itype     = 1'b1;
    case (w_op)
      OP_SPECIAL: begin
        w_itype = 1'b0;
        case (w_funct)
          FN_AND:  begin o_aluop = EXE_AND_OP;  o_alusel = EXE_RES_LOGIC;      end
          FN_OR:   begin o_aluop = EXE_OR_OP;   o_alusel = EXE_RES_LOGIC;      end
          FN_XOR:  begin o_aluop = EXE_XOR_OP;  o_alusel = EXE_RES_LOGIC;      end
          FN_NOR:  begin o_aluop = EXE_NOR_OP;  o_alusel = EXE_RES_LOGIC;      end
          FN_SLLV: begin o_aluop = EXE_SLLV_OP; o_alusel = EXE_RES_SHIFT;      end
          FN_SRLV: begin o_aluop = EXE_SRLV_OP; o_alusel = EXE_RES_SHIFT;      end
          FN_SRAV: begin o_aluop = EXE_SRAV_OP; o_alusel = EXE_RES_SHIFT;      end
          FN_SLL:  begin o_aluop = EXE_SLL_OP;  o_alusel = EXE_RES_SHIFT; w_shift_imm = 1'b1; end
          FN_SRL:  begin o_aluop = EXE_SRL_OP;  o_alusel = EXE_RES_SHIFT; w_shift_imm = 1'b1; end
          FN_SRA:  begin o_aluop = EXE_SRA_OP;  o_alusel = EXE_RES_SHIFT; w_shift_imm = 1'b1; end
          FN_SLT:  begin o_aluop = EXE_SLT_OP;  o_alusel = EXE_RES_ARITHMETIC; end
          FN_SLTU: begin o_aluop = EXE_SLTU_OP; o_alusel = EXE_RES_ARITHMETIC; end
          FN_ADD:  begin o_aluop = EXE_ADD_OP;  o_alusel = EXE_RES_ARITHMETIC; end
          FN_ADDU: begin o_aluop = EXE_ADDU_OP; o_alusel = EXE_RES_ARITHMETIC; end
          FN_SUB:  begin o_aluop = EXE_SUB_OP;  o_alusel = EXE_RES_ARITHMETIC; end
          FN_SUBU: begin o_aluop = EXE_SUBU_OP; o_alusel = EXE_RES_ARITHMETIC; end
          default: o_invalid = 1'b1;
        endcase
        if (!o_invalid) begin
          // Shift-by-immediate replaces the rs read with the shamt field
          o_re1  = !w_shift_imm;
          o_re2  = 1'b1;
          o_imm1 = w_shift_imm ? w_shamt : '0;
          o_wd   = REG_AW'(i_inst[15:11]);
          o_wreg = 1'b1;
        end
      end
      OP_ANDI:  begin o_aluop = EXE_AND_OP;  o_alusel = EXE_RES_LOGIC;      o_re1 = 1'b1; o_imm2 = w_zimm; end
      OP_ORI:   begin o_aluop = EXE_OR_OP;   o_alusel = EXE_RES_LOGIC;      o_re1 = 1'b1; o_imm2 = w_zimm; end
      OP_XORI:  begin o_aluop = EXE_XOR_OP;  o_alusel = EXE_RES_LOGIC;      o_re1 = 1'b1; o_imm2 = w_zimm; end
      OP_SLTI:  begin o_aluop = EXE_SLT_OP;  o_alusel = EXE_RES_ARITHMETIC; o_re1 = 1'b1; o_imm2 = w_simm; end
      OP_SLTIU: begin o_aluop = EXE_SLTU_OP; o_alusel = EXE_RES_ARITHMETIC; o_re1 = 1'b1; o_imm2 = w_simm; end
      OP_ADDI:  begin o_aluop = EXE_ADD_OP;  o_alusel = EXE_RES_ARITHMETIC; o_re1 = 1'b1; o_imm2 = w_simm; end
      OP_ADDIU: begin o_aluop = EXE_ADDU_OP; o_alusel = EXE_RES_ARITHMETIC; o_re1 = 1'b1; o_imm2 = w_simm; end
      // LUI is OR of a forced zero with the upper-half immediate
      OP_LUI:   begin o_aluop = EXE_OR_OP;   o_alusel = EXE_RES_LOGIC;
                      o_imm2 = DATA_W'({i_inst[15:0], 16'h0000}); end
      default: begin
        w_itype   = 1'b0;
        o_invalid = 1'b1;
      end
    endcase
    if (w_itype) begin
      o_wd   = REG_AW'(i_inst[20:16]);
      o_wreg = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : MIPS decode stage with operand resolution, hazard detection and
//            a handshaked ID/EX pipeline register.
//            ID_FORWARD_EN defined   : EX/MEM forwarding, load-use stalls only.
//            ID_FORWARD_EN undefined : regfile operands only, stall on any
//                                      in-flight EX/MEM writer of a source.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [31:0]       pc_o,
  output logic              inst_invalid_o
);

  logic [7:0]        w_aluop;
  logic [2:0]        w_alusel;
  logic              w_re1, w_re2, w_wreg, w_invalid;
  logic [REG_AW-1:0] w_wd, w_rs, w_rt;
  logic [DATA_W-1:0] w_imm1, w_imm2, w_op1, w_op2;
  logic              w_ex_hit, w_stall;

  logic              r_out_valid, r_wreg, r_invalid;
  logic [7:0]        r_aluop;
  logic [2:0]        r_alusel;
  logic [DATA_W-1:0] r_reg1, r_reg2;
  logic [REG_AW-1:0] r_wd;
  logic [31:0]       r_pc;

  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .i_inst    (inst_i),
    .o_aluop   (w_aluop),
    .o_alusel  (w_alusel),
    .o_re1     (w_re1),
    .o_re2     (w_re2),
    .o_wd      (w_wd),
    .o_wreg    (w_wreg),
    .o_imm1    (w_imm1),
    .o_imm2    (w_imm2),
    .o_invalid (w_invalid)
  );

  assign w_rs        = REG_AW'(inst_i[25:21]);
  assign w_rt        = REG_AW'(inst_i[20:16]);
  assign reg1_read_o = w_re1;
  assign reg2_read_o = w_re2;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  // Operand 1: decoded constant, hard-wired $0, forwarded result, then regfile
  always_comb begin
    if (!w_re1)                               w_op1 = w_imm1;
    else if (w_rs == '0)                      w_op1 = '0;
`ifdef ID_FORWARD_EN
    else if (ex_wreg_i  && (ex_wd_i  == w_rs)) w_op1 = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == w_rs)) w_op1 = mem_wdata_i;
`endif
    else                                      w_op1 = reg1_data_i;
  end

  // Operand 2: same priority as operand 1 with rt
  always_comb begin
    if (!w_re2)                               w_op2 = w_imm2;
    else if (w_rt == '0)                      w_op2 = '0;
`ifdef ID_FORWARD_EN
    else if (ex_wreg_i  && (ex_wd_i  == w_rt)) w_op2 = ex_wdata_i;
    else if (mem_wreg_i && (mem_wd_i == w_rt)) w_op2 = mem_wdata_i;
`endif
    else                                      w_op2 = reg2_data_i;
  end

  // A live EX writer of a nonzero register that one of our enabled reads needs
  assign w_ex_hit = ex_wreg_i && (ex_wd_i != '0) &&
                    ((w_re1 && (ex_wd_i == w_rs)) || (w_re2 && (ex_wd_i == w_rt)));

`ifdef ID_FORWARD_EN
  // Only a load's result is unavailable for forwarding this cycle
  assign w_stall = ex_is_load_i && w_ex_hit;
`else
  logic w_mem_hit;
  logic w_unused;
  assign w_mem_hit = mem_wreg_i && (mem_wd_i != '0) &&
                     ((w_re1 && (mem_wd_i == w_rs)) || (w_re2 && (mem_wd_i == w_rt)));
  // Without bypass paths any in-flight writer must retire first
  assign w_stall   = w_ex_hit || w_mem_hit;
  assign w_unused  = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};
`endif

  assign in_ready = !w_stall && (!r_out_valid || out_ready) && !flush_i;

  // ID/EX register: flush beats capture beats drain; a stall with a free slot drains to a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_out_valid <= 1'b0;
      r_aluop     <= EXE_NOP_OP;
      r_alusel    <= EXE_RES_NOP;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_wd        <= REG_AW'(NOPRegAddr);
      r_wreg      <= 1'b0;
      r_pc        <= ZeroWord;
      r_invalid   <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
      r_wreg      <= 1'b0;
      r_aluop     <= EXE_NOP_OP;
    end else if (in_valid && in_ready) begin
      r_out_valid <= 1'b1;
      r_aluop     <= w_aluop;
      r_alusel    <= w_alusel;
      r_reg1      <= w_op1;
      r_reg2      <= w_op2;
      r_wd        <= w_wd;
      r_wreg      <= w_wreg;
      r_pc        <= pc_i;
      r_invalid   <= w_invalid;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_o         = r_reg1;
  assign reg2_o         = r_reg2;
  assign wd_o           = r_wd;
  assign wreg_o         = r_wreg;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Scoreboard bench for id_stage. Expected bundles are queued at
//            issue time and popped by a monitor when EX accepts a bundle.
//            Expectations follow ID_FORWARD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;
  import id_stage_pkg::*;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        inv;
  } bund_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, flush_i, out_valid, out_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_invalid_o;

  bund_t act;
  bund_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  // Regfile model: every register (including $0) reads as A000_00nn
  assign reg1_data_i = 32'hA000_0000 | 32'(reg1_addr_o);
  assign reg2_data_i = 32'hA000_0000 | 32'(reg2_addr_o);
  assign act = {aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o};

  id_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_invalid_o(inst_invalid_o)
  );

  function automatic bund_t mk(input logic [7:0] aluop, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg,
                               input logic [31:0] pc, input logic inv);
    bund_t b;
    b.aluop = aluop; b.alusel = sel; b.r1 = r1; b.r2 = r2;
    b.wd = wd; b.wreg = wreg; b.pc = pc; b.inv = inv;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic chk_b(input string name, input bund_t a, input bund_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual aluop=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b pc=%h inv=%b required aluop=%h sel=%h r1=%h r2=%h wd=%0d wreg=%b pc=%h inv=%b",
               name, a.aluop, a.alusel, a.r1, a.r2, a.wd, a.wreg, a.pc, a.inv,
               e.aluop, e.alusel, e.r1, e.r2, e.wd, e.wreg, e.pc, e.inv);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk_b({name, "_bundle"}, act, mk(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 1'b0, 0, 1'b0));
  endtask

  // Present an instruction for one cycle; it must be accepted
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input bund_t e, input bit push);
    in_valid = 1'b1; inst_i = inst; pc_i = pc;
    @(negedge clk);
    chk($sformatf("in_ready_pc%0h", pc), 64'(in_ready), 64'd1);
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // The currently presented instruction must be refused this cycle
  task automatic stall_cycle(input string name);
    @(negedge clk);
    chk(name, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_wreg_i = 0; ex_is_load_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  // Monitor: every bundle EX accepts must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle actual pc=%h aluop=%h required none", pc_o, aluop_o);
      end else begin
        chk_b("bundle", act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bund_t h;
    in_valid = 0; inst_i = 0; pc_i = 0; flush_i = 0; out_ready = 1;
    clear_fwd();
    #1 rst = 1'b0;
    #1 check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back immediates and a shift
    issue(32'h3401_8001, 32'h100, mk(EXE_OR_OP,  EXE_RES_LOGIC,      32'h0,         32'h0000_8001, 5'd1,  1, 32'h100, 0), 1);
    issue(32'h2062_FFFF, 32'h104, mk(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'hA000_0003, 32'hFFFF_FFFF, 5'd2,  1, 32'h104, 0), 1);
    issue(32'h3C07_1234, 32'h108, mk(EXE_OR_OP,  EXE_RES_LOGIC,      32'h0,         32'h1234_0000, 5'd7,  1, 32'h108, 0), 1);
    issue(32'h31AC_FFFF, 32'h10C, mk(EXE_AND_OP, EXE_RES_LOGIC,      32'hA000_000D, 32'h0000_FFFF, 5'd12, 1, 32'h10C, 0), 1);
    issue(32'h000B_5103, 32'h110, mk(EXE_SRA_OP, EXE_RES_SHIFT,      32'h4,         32'hA000_000B, 5'd10, 1, 32'h110, 0), 1);
    idle(1);

    // Writes to $0 are never forwarded and never stall
    ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'h55;
    mem_wreg_i = 1; mem_wd_i = 0; mem_wdata_i = 32'h66;
    issue(32'h0000_1820, 32'h114, mk(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h0, 32'h0, 5'd3, 1, 32'h114, 0), 1);

    // ADD $3,$1,$2 with in-flight writers of the sources
`ifdef ID_FORWARD_EN
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'd5;
    mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'd7;
    issue(32'h0022_1820, 32'h118, mk(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'd5, 32'hA000_0002, 5'd3, 1, 32'h118, 0), 1);
    mem_wd_i = 2; mem_wdata_i = 32'd9;
    issue(32'h0022_1820, 32'h11C, mk(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'd5, 32'd9, 5'd3, 1, 32'h11C, 0), 1);
`else
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'd5;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'd9;
    inst_i = 32'h0022_1820; pc_i = 32'h118; in_valid = 1;
    stall_cycle("raw_ex_mem_stall");
    ex_wreg_i = 0; mem_wd_i = 1; mem_wdata_i = 32'd5;
    stall_cycle("raw_mem_stall");
    mem_wreg_i = 0;
    issue(32'h0022_1820, 32'h118, mk(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'hA000_0001, 32'hA000_0002, 5'd3, 1, 32'h118, 0), 1);
`endif
    clear_fwd();
    idle(1);

    // Load-use: ORI then AND $5,$4,$6 while EX holds a load to $4
    issue(32'h3401_8001, 32'h120, mk(EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h0000_8001, 5'd1, 1, 32'h120, 0), 1);
    inst_i = 32'h0086_2824; pc_i = 32'h124; in_valid = 1;
    ex_wreg_i = 1; ex_is_load_i = 1; ex_wd_i = 4; ex_wdata_i = 32'h1111;
    stall_cycle("load_use_stall");
    chk("load_use_bubble", 64'(out_valid), 64'd0);
    ex_wreg_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h44;
`ifdef ID_FORWARD_EN
    issue(32'h0086_2824, 32'h124, mk(EXE_AND_OP, EXE_RES_LOGIC, 32'h44, 32'hA000_0006, 5'd5, 1, 32'h124, 0), 1);
`else
    stall_cycle("load_use_mem_stall");
    mem_wreg_i = 0;
    issue(32'h0086_2824, 32'h124, mk(EXE_AND_OP, EXE_RES_LOGIC, 32'hA000_0004, 32'hA000_0006, 5'd5, 1, 32'h124, 0), 1);
`endif
    clear_fwd();
    idle(1);

    // Unrecognised funct and opcode flow as invalid NOP bundles
    inst_i = 32'h0022_183F; #1;
    chk("invalid_read_en", 64'({reg1_read_o, reg2_read_o}), 64'd0);
    issue(32'h0022_183F, 32'h130, mk(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 0, 32'h130, 1), 1);
    issue(32'hFC00_0000, 32'h134, mk(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 0, 32'h134, 1), 1);
    idle(2);

    // Backpressure: XORI held for 3 cycles, then flushed
    out_ready = 0;
    h = mk(EXE_XOR_OP, EXE_RES_LOGIC, 32'hA000_0009, 32'h0000_00F0, 5'd8, 1, 32'h140, 0);
    issue(32'h3928_00F0, 32'h140, h, 0);
    inst_i = 32'h3401_8001; pc_i = 32'h144; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b($sformatf("hold_bundle_%0d", i), act, h);
      chk($sformatf("hold_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold_in_ready_%0d", i), 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    flush_i = 1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush_i = 0; in_valid = 0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_wreg", 64'(wreg_o), 64'd0);
    chk("flush_aluop", 64'(aluop_o), 64'(EXE_NOP_OP));
    out_ready = 1;
    idle(1);

    // Asynchronous reset while a bundle is held
    out_ready = 0;
    issue(32'h3401_8001, 32'h150, mk(EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h0000_8001, 5'd1, 1, 32'h150, 0), 0);
    #2;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
